// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, next-PC source codes and the load-use test.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    EXC      = 2'd2
  } state_e;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_EXC = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // r0 is hardwired, so a load targeting it can never create a dependency.
  function automatic logic is_load_use(input logic       mem_read,
                                       input logic [4:0] rw,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt);
    return mem_read && (rw != REG_ZERO) && ((rw == rs) || (rw == rt));
  endfunction

endpackage

// File: rtl/mdu_timer.sv
// Down-counter tracking the multiply/divide unit's in-flight operation.
// busy is high for exactly MDU_LAT cycles after load; clear cancels immediately.
module mdu_timer #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic busy,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= CNT_W'(MDU_LAT - 1);
      busy <= 1'b1;
    end else if (busy) begin
      // The zero-count cycle is still a busy cycle; busy drops after it.
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign last = busy && (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipeline: stalls, flushes, next-PC select.
// Responses are same-cycle combinational; FSM and MDU counter update on posedge.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_mdu_use,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_Rw,
  input  logic       ex_mdu_start,
  input  logic       ex_br_taken,
  input  logic       mem_overflow,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic [1:0] pc_sel,
  output logic       mdu_busy,
  output logic       mdu_abort
);

  state_e state;
  logic   busy;
  logic   last;
  logic   load_use;
  logic   mdu_stall;
  logic   overflow_act;
  logic   tmr_load;

  assign load_use  = is_load_use(ex_MemRead, ex_Rw, id_rs, id_rt);
  assign mdu_stall = busy && id_mdu_use;

  // An overflow cannot recur in the cycle right after one, so EXC masks it.
  assign overflow_act = !rst && (state != EXC) && mem_overflow;
  assign tmr_load     = !rst && (state == RUN) && !mem_overflow && ex_mdu_start;

  mdu_timer #(
    .MDU_LAT(MDU_LAT),
    .CNT_W  (CNT_W)
  ) u_mdu_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .clear(overflow_act),
    .busy (busy),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (mem_overflow) begin
            state <= EXC;
          end else if (ex_mdu_start) begin
            state <= MDU_WAIT;
          end
        end
        MDU_WAIT: begin
          if (mem_overflow) begin
            state <= EXC;
          end else if (last) begin
            state <= RUN;
          end
        end
        EXC:     state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_sel      = PC_SEQ;
    mdu_busy    = busy && !rst;
    mdu_abort   = 1'b0;

    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (state == EXC) begin
      pc_sel = PC_SEQ;
    end else if (overflow_act) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      pc_sel      = PC_EXC;
      mdu_abort   = (state == MDU_WAIT);
    end else if (ex_br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pc_sel     = PC_BR;
    end else if (load_use || mdu_stall) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipelined CPU. It drives the write-enables and flushes of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers, and selects the next-PC source. Cases handled: load-use stalls, taken-branch flushes, MEM-stage overflow exceptions, and interlocks against the multi-cycle multiply/divide unit (MDU). It sits beside the datapath, takes decoded fields from ID/EX/MEM, and returns control only.

## Interface
- MDU_LAT, 32, MDU busy cycles after a mult/div issues from EX (legal 2..255)
- CNT_W, 8, width of the MDU cycle counter (must hold MDU_LAT-1)

- clk  in  1  clock; state updates on posedge
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_mdu_use  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div
- ex_MemRead  in  1  EX instruction is a load
- ex_Rw  in  5  destination register of the EX instruction
- ex_mdu_start  in  1  EX instruction is mult/div (one-cycle pulse per instruction)
- ex_br_taken  in  1  branch/jump in EX resolved taken
- mem_overflow  in  1  MEM instruction raised arithmetic overflow
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a NOP bubble into that register
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = exception vector, 3 reserved (never driven)
- mdu_busy  out  1  MDU result not yet valid
- mdu_abort  out  1  one-cycle pulse: in-flight MDU operation cancelled

## Operation
- State register: RUN, MDU_WAIT, EXC. Down-counter `cnt[CNT_W-1:0]`.
- Outputs are combinational from the current state, `cnt` and the inputs. The pipeline registers sample on negedge, so outputs settle within the first half-cycle.
- Condition priority, highest first, one condition acted on per cycle:
  1. rst
  2. mem_overflow
  3. ex_br_taken
  4. load-use
  5. MDU interlock
- rst:
  - pc_we=0, ifid_we=0, all three flushes=1, pc_sel=0, mdu_busy=0, mdu_abort=0
  - next state RUN, cnt=0
- mem_overflow:
  - exmem_flush=idex_flush=ifid_flush=1, pc_sel=2, pc_we=1
  - if state is MDU_WAIT: mdu_abort=1 and cnt cleared
  - a coincident ex_mdu_start is ignored
  - next state EXC
- EXC: lasts exactly one cycle.
  - pc_we=1, ifid_we=1, no flush, pc_sel=0
  - a new overflow in this cycle is not possible; any mem_overflow input is ignored
  - next state RUN
- ex_br_taken:
  - ifid_flush=idex_flush=1, pc_sel=1, pc_we=1
  - does not abort the MDU; the state is unchanged
- Load-use: ex_MemRead && ex_Rw!=0 && (ex_Rw==id_rs || ex_Rw==id_rt)
  - pc_we=0, ifid_we=0, idex_flush=1
  - one bubble only; the next cycle re-evaluates naturally
- MDU interlock: mdu_busy && id_mdu_use
  - pc_we=0, ifid_we=0, idex_flush=1
  - repeats every cycle until mdu_busy falls
- Default: pc_we=1, ifid_we=1, flushes=0, pc_sel=0.
- MDU sequencing:
  - ex_mdu_start in RUN: cnt loads MDU_LAT-1, next state MDU_WAIT
  - MDU_WAIT: mdu_busy=1, cnt decrements each cycle
  - cnt==0: mdu_busy is still 1 in that cycle; next state RUN
  - ex_mdu_start never arrives in MDU_WAIT, because the interlock prevents a second mult/div passing ID

## Timing
- Stall/flush response is same-cycle (0 latency).
- State and counter change on the following posedge.
- MDU: mdu_busy is high for exactly MDU_LAT cycles, starting the cycle after ex_mdu_start.
- mdu_abort: a single cycle.
- Reset is synchronous: an asserted rst overrides every input in the same cycle.
- Reset mid-MDU clears the counter without pulsing mdu_abort.

## Structure
- Shared package `pipe_pkg`:
  - state enum (RUN/MDU_WAIT/EXC)
  - pc_sel codes PC_SEQ=0, PC_BR=1, PC_EXC=2
  - register-0 constant
- Sub-module `mdu_timer`:
  - holds cnt, load/decrement/clear logic, and the busy flag
  - parameterised by MDU_LAT and CNT_W
- The FSM and the priority mux stay in the top level.

## Test plan
- Reset:
  - rst=1 for 2 cycles, then 0 → during rst pc_we=0, all flushes=1
  - first cycle after release: pc_we=1, pc_sel=0, mdu_busy=0
- Load-use:
  - ex_MemRead=1, ex_Rw=8, id_rt=8 → exactly one cycle of pc_we=0, ifid_we=0, idex_flush=1
  - with ex_Rw=0 → no stall
- Branch vs load-use:
  - ex_br_taken=1 together with the load-use condition → pc_sel=1, ifid_flush=idex_flush=1, pc_we=1 (no stall)
- MDU, MDU_LAT=4:
  - ex_mdu_start pulse → mdu_busy high for 4 cycles
  - id_mdu_use=1 throughout → stall for 4 cycles, released in the 5th
- Overflow mid-MDU:
  - mem_overflow at cycle 2 of MDU_WAIT → mdu_abort=1 for one cycle, all flushes=1, pc_sel=2
  - next cycle: EXC with pc_sel=0; the cycle after: RUN with mdu_busy=0
- Simultaneous overflow and ex_mdu_start:
  - no MDU_WAIT entry, mdu_busy stays 0, pc_sel=2
